// File: rtl/echo_pkg.sv
// Shared definitions for the echo tap scheduler.
//   SAMPLE_W / ADDR_W : audio word and RAM address widths
//   DEF_NUM_TAPS      : default tap count
//   DEF_RAM_DEPTH     : default sample-buffer depth (one second at 48 kHz)
//   state_t           : sequencer states, one pass per accepted sample
package echo_pkg;

    localparam int SAMPLE_W      = 16;
    localparam int ADDR_W        = 16;
    localparam int DEF_NUM_TAPS  = 4;
    localparam int DEF_RAM_DEPTH = 48000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/ring_addr_sub.sv
// Ring-buffer read address: (ptr - delay) mod RAM_DEPTH, purely combinational.
//   ptr   : current write pointer, always < RAM_DEPTH
//   delay : requested delay in samples; 0 reads as 1, >= RAM_DEPTH reads as RAM_DEPTH-1
//   addr  : resulting buffer address
module ring_addr_sub
    import echo_pkg::*;
#(
    parameter int RAM_DEPTH = DEF_RAM_DEPTH
) (
    input  logic [ADDR_W-1:0]   ptr,
    input  logic [SAMPLE_W-1:0] delay,
    output logic [ADDR_W-1:0]   addr
);

    localparam int              DW    = ADDR_W + 1;
    localparam logic [DW-1:0]   DEPTH = DW'(RAM_DEPTH);

    logic [DW-1:0] dly;

    always_comb begin
        dly = {1'b0, delay};
        if (delay == '0) begin
            dly = DW'(1);
        end else if (dly >= DEPTH) begin
            dly = DEPTH - DW'(1);
        end

        // On borrow, fold back by one buffer length. The true result is
        // below RAM_DEPTH, so ADDR_W-bit wrapping arithmetic is exact.
        if ({1'b0, ptr} >= dly) begin
            addr = ptr - dly[ADDR_W-1:0];
        end else begin
            addr = ptr + DEPTH[ADDR_W-1:0] - dly[ADDR_W-1:0];
        end
    end

endmodule

// File: rtl/echo_tap_scheduler.sv
// Echo tap scheduler: per accepted sample, writes it into a ring buffer held
// in a single-port RAM, then reads NUM_TAPS delayed samples back through the
// same port and presents them together.
//   clk_in, rst_in        : clock, synchronous active-high reset
//   audio_valid_in        : new-sample strobe (accepted only when idle)
//   audio_in              : signed sample
//   store_audio_in        : write the sample into the buffer
//   tap_delay_in          : per-tap delay in samples
//   tap_enable_in         : per-tap enable; disabled taps read back as 0
//   ram_addr_out/we/din   : shared RAM port, ram_dout_in arrives RAM_LATENCY later
//   taps_out              : tap results, held until the next result set
//   taps_valid_out        : one-cycle pulse when taps_out is updated
//   busy_out              : sequence in progress
//   overrun_out           : one-cycle pulse when a strobe is dropped
module echo_tap_scheduler
    import echo_pkg::*;
#(
    parameter int NUM_TAPS    = DEF_NUM_TAPS,
    parameter int RAM_DEPTH   = DEF_RAM_DEPTH,
    parameter int RAM_LATENCY = 2
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic                               audio_valid_in,
    input  logic [SAMPLE_W-1:0]                audio_in,
    input  logic                               store_audio_in,
    input  logic [NUM_TAPS-1:0][SAMPLE_W-1:0]  tap_delay_in,
    input  logic [NUM_TAPS-1:0]                tap_enable_in,
    output logic [ADDR_W-1:0]                  ram_addr_out,
    output logic                               ram_we_out,
    output logic [SAMPLE_W-1:0]                ram_din_out,
    input  logic [SAMPLE_W-1:0]                ram_dout_in,
    output logic [NUM_TAPS-1:0][SAMPLE_W-1:0]  taps_out,
    output logic                               taps_valid_out,
    output logic                               busy_out,
    output logic                               overrun_out
);

    localparam int                TAP_W     = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam logic [TAP_W-1:0]  LAST_TAP  = TAP_W'(NUM_TAPS - 1);
    localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(RAM_DEPTH - 1);

    state_t state, state_nxt;

    logic [ADDR_W-1:0]                  wr_ptr;
    logic [SAMPLE_W-1:0]                sample_q;
    logic                               store_q;
    logic [NUM_TAPS-1:0][SAMPLE_W-1:0]  dly_q;
    logic [NUM_TAPS-1:0]                en_q;
    logic [TAP_W-1:0]                   rd_idx;
    logic [ADDR_W-1:0]                  rd_addr;

    // Read-return tracking: which tap each in-flight read belongs to.
    logic [RAM_LATENCY-1:0]             vld_pipe;
    logic [RAM_LATENCY-1:0][TAP_W-1:0]  idx_pipe;
    logic [NUM_TAPS-1:0][SAMPLE_W-1:0]  cap_q, cap_nxt;
    logic                               ret_vld;
    logic [TAP_W-1:0]                   ret_idx;
    logic                               last_cap;

    ring_addr_sub #(.RAM_DEPTH(RAM_DEPTH)) u_ring (
        .ptr   (wr_ptr),
        .delay (dly_q[rd_idx]),
        .addr  (rd_addr)
    );

    assign ret_vld  = vld_pipe[RAM_LATENCY-1];
    assign ret_idx  = idx_pipe[RAM_LATENCY-1];
    assign last_cap = ret_vld && (ret_idx == LAST_TAP);

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        busy_out       = (state != ST_IDLE);
        taps_valid_out = (state == ST_DONE);
        ram_addr_out   = '0;
        ram_we_out     = 1'b0;
        ram_din_out    = '0;
        case (state)
            ST_IDLE:  if (audio_valid_in) state_nxt = ST_WRITE;
            ST_WRITE: begin
                ram_addr_out = wr_ptr;
                ram_din_out  = sample_q;
                ram_we_out   = store_q;
                state_nxt    = ST_READ;
            end
            ST_READ: begin
                ram_addr_out = rd_addr;
                if (rd_idx == LAST_TAP) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: if (last_cap) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cap_nxt = cap_q;
        if (ret_vld) cap_nxt[ret_idx] = en_q[ret_idx] ? ram_dout_in : '0;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr      <= '0;
            sample_q    <= '0;
            store_q     <= 1'b0;
            dly_q       <= '0;
            en_q        <= '0;
            rd_idx      <= '0;
            vld_pipe    <= '0;
            idx_pipe    <= '0;
            cap_q       <= '0;
            taps_out    <= '0;
            overrun_out <= 1'b0;
        end else begin
            overrun_out <= audio_valid_in && (state != ST_IDLE);

            if (state == ST_IDLE && audio_valid_in) begin
                sample_q <= audio_in;
                store_q  <= store_audio_in;
                dly_q    <= tap_delay_in;
                en_q     <= tap_enable_in;
                rd_idx   <= '0;
            end
            if (state == ST_READ) rd_idx <= rd_idx + TAP_W'(1);

            vld_pipe[0] <= (state == ST_READ);
            idx_pipe[0] <= rd_idx;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                idx_pipe[i] <= idx_pipe[i-1];
            end

            cap_q <= cap_nxt;
            // Publish on the edge entering DONE so taps_out is already
            // valid during the taps_valid_out pulse.
            if (state == ST_DRAIN && last_cap) taps_out <= cap_nxt;

            if (state == ST_DONE) wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + ADDR_W'(1);
        end
    end

endmodule

// File: tb/tb_echo_tap_scheduler.sv
// Bench for echo_tap_scheduler. The buffer depth is scaled down to 24 (still
// not a power of two) so that pointer wrap is reachable in a short run.
// Expected values come from a plain ring-buffer model: a reference copy of
// the RAM contents, a write pointer, and delay arithmetic using %.
module tb_echo_tap_scheduler;

    localparam int NT     = 4;
    localparam int LAT    = 2;
    localparam int DEPTH  = 24;
    localparam int AW     = $clog2(DEPTH);
    localparam int DONE_C = 2 + NT + LAT;

    logic                clk = 1'b0;
    logic                rst;
    logic                audio_valid;
    logic [15:0]         audio;
    logic                store;
    logic [NT-1:0][15:0] tap_delay;
    logic [NT-1:0]       tap_enable;
    logic [15:0]         ram_addr;
    logic                ram_we;
    logic [15:0]         ram_din;
    logic [15:0]         ram_dout;
    logic [NT-1:0][15:0] taps;
    logic                taps_valid;
    logic                busy;
    logic                overrun;

    always #5 clk = ~clk;

    echo_tap_scheduler #(.NUM_TAPS(NT), .RAM_DEPTH(DEPTH), .RAM_LATENCY(LAT)) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .audio_valid_in (audio_valid),
        .audio_in       (audio),
        .store_audio_in (store),
        .tap_delay_in   (tap_delay),
        .tap_enable_in  (tap_enable),
        .ram_addr_out   (ram_addr),
        .ram_we_out     (ram_we),
        .ram_din_out    (ram_din),
        .ram_dout_in    (ram_dout),
        .taps_out       (taps),
        .taps_valid_out (taps_valid),
        .busy_out       (busy),
        .overrun_out    (overrun)
    );

    function automatic logic [15:0] init_val(int a);
        return 16'(a * 131 + 'h1234);
    endfunction

    // Single-port RAM, two-cycle read latency, preloaded on the first edge.
    logic [15:0] ram [DEPTH];
    logic [15:0] rd1, rd2;
    bit          ram_ready = 1'b0;
    assign ram_dout = rd2;

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= init_val(i);
            ram_ready <= 1'b1;
        end else if (ram_we && ram_addr < 16'(DEPTH)) begin
            ram[AW'(ram_addr)] <= ram_din;
        end
        rd1 <= (ram_addr < 16'(DEPTH)) ? ram[AW'(ram_addr)] : 16'hdead;
        rd2 <= rd1;
    end

    // Reference model state
    logic [15:0] ref_mem [DEPTH];
    int          ptr;
    int          checks = 0;
    int          errors = 0;

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int clampd(int d);
        if (d == 0) return 1;
        if (d >= DEPTH) return DEPTH - 1;
        return d;
    endfunction

    // One full sample pass, checked cycle by cycle against the model.
    // ovr_at > 0 injects an extra strobe in that cycle after acceptance.
    task automatic run_sample(input logic [15:0] s, input logic st,
                              input logic [NT-1:0][15:0] d, input logic [NT-1:0] en,
                              input int ovr_at);
        int                  ea [NT];
        logic [NT-1:0][15:0] et;
        for (int k = 0; k < NT; k++) begin
            ea[k] = (ptr - clampd(int'(d[k])) + DEPTH) % DEPTH;
            et[k] = en[k] ? ref_mem[ea[k]] : 16'h0;
        end
        audio       = s;
        store       = st;
        tap_delay   = d;
        tap_enable  = en;
        audio_valid = 1'b1;
        for (int c = 1; c <= DONE_C + 1; c++) begin
            step();
            audio_valid = (c == ovr_at);
            if (c == ovr_at) begin
                audio     = ~s;
                store     = 1'b1;
                tap_delay = '0;
            end
            chk1("busy", busy, c <= DONE_C);
            chk1("we", ram_we, c == 1 && st);
            chk1("taps_valid", taps_valid, c == DONE_C);
            chk1("overrun", overrun, ovr_at > 0 && c == ovr_at + 1);
            if (c == 1) begin
                chk16("wr_addr", ram_addr, 16'(ptr));
                chk16("wr_data", ram_din, s);
            end
            if (c >= 2 && c < 2 + NT) chk16("rd_addr", ram_addr, 16'(ea[c-2]));
            if (c >= DONE_C)
                for (int k = 0; k < NT; k++) chk16("taps", taps[k], et[k]);
        end
        audio_valid = 1'b0;
        if (st) ref_mem[ptr] = s;
        ptr = (ptr + 1) % DEPTH;
    endtask

    initial begin
        logic [NT-1:0][15:0] dd;
        logic [NT-1:0]       ee;
        logic [15:0]         s;

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
        ptr         = 0;
        rst         = 1'b1;
        audio_valid = 1'b1;       // reset must win over a strobe
        audio       = 16'h7777;
        store       = 1'b1;
        tap_delay   = '0;
        tap_enable  = '1;
        step();
        step();
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_we", ram_we, 1'b0);
        chk16("rst_addr", ram_addr, 16'h0);
        chk16("rst_din", ram_din, 16'h0);
        chk1("rst_taps_valid", taps_valid, 1'b0);
        chk1("rst_overrun", overrun, 1'b0);
        for (int k = 0; k < NT; k++) chk16("rst_taps", taps[k], 16'h0);
        rst         = 1'b0;
        audio_valid = 1'b0;
        step();
        chk1("idle_busy", busy, 1'b0);

        // Samples 1..10, delays 1..4, all taps enabled
        for (int k = 0; k < NT; k++) dd[k] = 16'(k + 1);
        for (int i = 1; i <= 10; i++) run_sample(16'(i), 1'b1, dd, '1, 0);
        for (int k = 0; k < NT; k++) chk16("seq10_taps", taps[k], 16'(9 - k));

        // Randomized samples, delays (incl. 0 and oversize), enables, store flag
        for (int i = 0; i < 12; i++) begin
            for (int k = 0; k < NT; k++) begin
                case ($urandom_range(0, 3))
                    0:       dd[k] = 16'd0;
                    1:       dd[k] = 16'd60000;
                    default: dd[k] = 16'($urandom_range(1, DEPTH + 4));
                endcase
            end
            ee = NT'($urandom);
            run_sample(16'($urandom), $urandom_range(0, 3) != 0, dd, ee, 0);
        end

        // Walk up to the last slot, then cross the wrap with delay 2
        for (int k = 0; k < NT; k++) dd[k] = 16'(k + 1);
        while (ptr != DEPTH - 1) run_sample(16'($urandom), 1'b1, dd, '1, 0);
        dd = {NT{16'd2}};
        run_sample(16'h1111, 1'b1, dd, '1, 0);   // reads slot DEPTH-3
        run_sample(16'h2222, 1'b1, dd, '1, 0);   // ptr 0, reads slot DEPTH-2

        // Clamped delays with the last tap disabled
        dd = {16'd5, 16'd5, 16'd60000, 16'd0};
        run_sample(16'h3333, 1'b1, dd, 4'b0111, 0);
        chk16("disabled_tap", taps[3], 16'h0);

        // Unstored sample: its slot keeps the earlier contents
        s = ref_mem[ptr];
        run_sample(16'hbeef, 1'b0, dd, '1, 0);
        dd = {16'd4, 16'd3, 16'd2, 16'd1};
        run_sample(16'h4444, 1'b1, dd, '1, 0);
        chk16("unstored_slot", taps[0], s);

        // Overrun three cycles after acceptance, then in the DONE cycle
        run_sample(16'($urandom), 1'b1, dd, '1, 3);
        run_sample(16'($urandom), 1'b1, dd, '1, DONE_C);
        run_sample(16'($urandom), 1'b1, dd, '1, 0);

        // Reset during READ aborts the sequence
        audio       = 16'h5555;
        store       = 1'b1;
        tap_delay   = dd;
        tap_enable  = '1;
        audio_valid = 1'b1;
        step();
        audio_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_taps_valid", taps_valid, 1'b0);
        chk1("abort_we", ram_we, 1'b0);
        rst = 1'b0;
        ref_mem[ptr] = 16'h5555;   // WRITE completed before the abort
        ptr = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk1("abort_no_valid", taps_valid, 1'b0);
            chk1("abort_no_we", ram_we, 1'b0);
        end
        run_sample(16'h6666, 1'b1, dd, '1, 0);
        run_sample(16'h7777, 1'b1, dd, '1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/echo_tap_scheduler.md
ECHO_TAP_SCHEDULER -- requirements
Module: echo_tap_scheduler

Interface
REQ-001 SHALL have parameter NUM_TAPS, default 4, number of delay taps read per sample.
REQ-002 SHALL have parameter RAM_DEPTH, default 48000, sample-buffer depth in words.
REQ-003 SHALL have parameter RAM_LATENCY, default 2, cycles from ram_addr_out to valid ram_dout_in.
REQ-004 SHALL have: clk_in input 1, the single clock; rst_in input 1, reset that is synchronous and active-high.
REQ-005 SHALL have: audio_valid_in input 1, one-cycle new-sample strobe; audio_in input 16, signed sample.
REQ-006 SHALL have: store_audio_in input 1, write enable for the current sample.
REQ-007 SHALL have: tap_delay_in input NUM_TAPS x 16, per-tap delay in samples; tap_enable_in input NUM_TAPS, per-tap enable.
REQ-008 SHALL have: ram_addr_out output 16, ram_we_out output 1, ram_din_out output 16, ram_dout_in input 16 (single shared RAM port).
REQ-009 SHALL have: taps_out output NUM_TAPS x 16, taps_valid_out output 1, busy_out output 1, overrun_out output 1.

Function
REQ-010 SHALL sequence one RAM port per sample via FSM: IDLE -> WRITE -> READ -> DRAIN -> DONE -> IDLE.
REQ-011 IDLE: on audio_valid_in, SHALL latch audio_in, store_audio_in, tap_delay_in, tap_enable_in; go WRITE next cycle.
REQ-012 WRITE (1 cycle): ram_addr_out=wr_ptr, ram_din_out=latched sample, ram_we_out=latched store flag.
REQ-013 READ (NUM_TAPS cycles): cycle k issues ram_addr_out=(wr_ptr - d_k) mod RAM_DEPTH, ram_we_out=0; d_k = latched delay of tap k.
REQ-014 Delay clamp: d_k=0 SHALL be treated as 1; d_k>=RAM_DEPTH SHALL be treated as RAM_DEPTH-1.
REQ-015 Modular subtract SHALL add RAM_DEPTH on borrow; no % operator on non-power-of-two depth.
REQ-016 Tap k data SHALL be captured from ram_dout_in RAM_LATENCY cycles after its address cycle; disabled taps capture 0.
REQ-017 DRAIN SHALL wait until last tap captured; DONE SHALL pulse taps_valid_out one cycle, then return IDLE.
REQ-018 Latency: audio_valid_in at cycle 0 -> taps_valid_out at cycle 2+NUM_TAPS+RAM_LATENCY (8 at defaults).
REQ-019 taps_out SHALL hold stable from taps_valid_out until next taps_valid_out.
REQ-020 wr_ptr SHALL increment in DONE regardless of store flag; RAM_DEPTH-1 wraps to 0.
REQ-021 busy_out SHALL be 1 in every state except IDLE.
REQ-022 audio_valid_in while busy_out=1 SHALL drop the sample and pulse overrun_out one cycle; in-flight sequence unaffected.
REQ-023 audio_valid_in in the DONE cycle counts as overrun (busy); accepted only in IDLE.
REQ-024 ram_we_out SHALL be 0 in every state except WRITE.

Reset
REQ-025 rst_in SHALL force IDLE, wr_ptr=0, ram_addr_out=0, ram_we_out=0, ram_din_out=0, taps_out=0, taps_valid_out=0, busy_out=0, overrun_out=0.
REQ-026 rst_in mid-sequence SHALL abort with no taps_valid_out pulse and no further RAM write.
REQ-027 rst_in SHALL take priority over simultaneous audio_valid_in.

Structure
REQ-028 Shared package echo_pkg SHALL hold FSM state enum, sample width 16, default NUM_TAPS and RAM_DEPTH.
REQ-029 One sub-module ring_addr_sub SHALL compute clamped (ptr - delay) mod RAM_DEPTH combinationally.
REQ-030 Capture SHALL use a RAM_LATENCY-deep shift register of tap index and valid, not counters per tap.

Verification
REQ-031 Reset, then 10 samples 1..10 with delays {1,2,3,4}, all enabled, 2-cycle RAM model -> 10th taps_out={9,8,7,6}, each 8 cycles after strobe.
REQ-032 wr_ptr at 47999, delay 2 -> read address 47997; next sample wr_ptr=0, delay 2 -> address 47998.
REQ-033 audio_valid_in 3 cycles after accepted strobe -> overrun_out one pulse, single taps_valid_out, wr_ptr advances by 1.
REQ-034 Delays {0,60000,5,5}, tap_enable=4'b0111 -> reads at wr_ptr-1, wr_ptr-47999, wr_ptr-5; taps_out[3]=0.
REQ-035 store_audio_in=0 for sample 5 -> no write in its WRITE cycle, wr_ptr still advances; later delay-1 tap read of that slot returns prior contents.
REQ-036 rst_in asserted during READ -> next cycle busy_out=0, no taps_valid_out, following sample writes address 0.
